// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock.
// Optional zeroize input port enabled by defining AES_KS_ZEROIZE_EN.
module aes_key_schedule_seq #(
    parameter int MAX_NK    = 8,
    parameter int KEY_W     = 32 * MAX_NK,
    parameter int MAX_WORDS = 4 * (MAX_NK + 7)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_size,
    input  logic [KEY_W-1:0] key,
`ifdef AES_KS_ZEROIZE_EN
    input  logic             zeroize,
`endif
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    output logic             err,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk_data,
    output logic             rk_valid
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [3:0] MaxNkL    = 4'(MAX_NK);
    localparam logic [6:0] MaxWordsL = 7'(MAX_WORDS);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      stateQ;
    state_t      stateD;
    logic [31:0] wordBuf [MAX_WORDS];
    logic [5:0]  wrIdx;
    logic [3:0]  nkQ;
    logic [3:0]  nrQ;
    logic [5:0]  totalQ;
    logic [3:0]  phase;
    logic [7:0]  rcon;

    logic        zeroReq;
    logic [3:0]  reqNk;
    logic [3:0]  reqNr;
    logic [5:0]  reqTotal;
    logic        reqLegal;
    logic        accept;
    logic        badReq;
    logic        lastWord;

    logic [31:0] prevWord;
    logic [31:0] backWord;
    logic [31:0] sbIn;
    logic [31:0] sbOut;
    logic [31:0] temp;
    logic [31:0] newWord;

    logic [5:0]   rdBase;
    logic         rdInRange;
    logic [127:0] readWord;
    logic         readOk;

`ifdef AES_KS_ZEROIZE_EN
    assign zeroReq = zeroize;
`else
    assign zeroReq = 1'b0;
`endif

    always_comb begin
        reqNk    = 4'd4;
        reqNr    = 4'd10;
        reqTotal = 6'd44;
        reqLegal = 1'b0;
        unique case (1'b1)
            (key_size == 2'd0): begin
                reqNk    = 4'd4;
                reqNr    = 4'd10;
                reqTotal = 6'd44;
                reqLegal = 1'b1;
            end
            (key_size == 2'd1): begin
                reqNk    = 4'd6;
                reqNr    = 4'd12;
                reqTotal = 6'd52;
                reqLegal = 1'b1;
            end
            (key_size == 2'd2): begin
                reqNk    = 4'd8;
                reqNr    = 4'd14;
                reqTotal = 6'd60;
                reqLegal = 1'b1;
            end
            default: reqLegal = 1'b0;
        endcase
        // A key longer than the buffer was sized for is refused like key_size=3.
        if (reqNk > MaxNkL) begin
            reqLegal = 1'b0;
        end
    end

    assign accept   = (stateQ == IDLE) && start && reqLegal && !zeroReq;
    assign badReq   = (stateQ == IDLE) && start && !reqLegal && !zeroReq;
    assign lastWord = (wrIdx == totalQ - 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (accept) stateD = EXPAND;
            EXPAND:  if (lastWord) stateD = DONE;
            DONE:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
        if (zeroReq) begin
            stateD = IDLE;
        end
    end

    assign busy = (stateQ == EXPAND);
    assign done = (stateQ == DONE);

    always_comb begin
        prevWord = wordBuf[wrIdx - 6'd1];
        backWord = wordBuf[wrIdx - {2'b00, nkQ}];
        sbIn     = (phase == 4'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
        sbOut    = subWord(sbIn);
        temp     = prevWord;
        if (phase == 4'd0) begin
            temp = sbOut ^ {rcon, 24'h0};
        end else if (nkQ == 4'd8 && phase == 4'd4) begin
            temp = sbOut;
        end
        newWord = backWord ^ temp;
    end

    // Word 4r+3 counts as present only if it was written before this edge.
    always_comb begin
        rdBase    = {rk_idx, 2'b00};
        rdInRange = ({1'b0, rk_idx, 2'b11} < MaxWordsL);
        readWord  = '0;
        if (rdInRange) begin
            readWord = {wordBuf[rdBase], wordBuf[rdBase + 6'd1],
                        wordBuf[rdBase + 6'd2], wordBuf[rdBase + 6'd3]};
        end
        readOk = rdInRange && (rk_idx <= nrQ) &&
                 ({rk_idx, 2'b11} < wrIdx) && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < MAX_WORDS; j++) begin
                wordBuf[j] <= '0;
            end
            wrIdx     <= '0;
            nkQ       <= 4'd4;
            nrQ       <= 4'd10;
            totalQ    <= 6'd44;
            phase     <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
            err       <= 1'b0;
            rk_data   <= '0;
            rk_valid  <= 1'b0;
        end else if (zeroReq) begin
            for (int j = 0; j < MAX_WORDS; j++) begin
                wordBuf[j] <= '0;
            end
            wrIdx     <= '0;
            phase     <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
            rk_data   <= '0;
            rk_valid  <= 1'b0;
        end else begin
            rk_data  <= readWord;
            rk_valid <= readOk;
            if (accept) begin
                for (int j = 0; j < MAX_NK; j++) begin
                    if (j < int'(reqNk)) begin
                        wordBuf[j] <= key[KEY_W-1-32*j -: 32];
                    end
                end
                nkQ       <= reqNk;
                nrQ       <= reqNr;
                totalQ    <= reqTotal;
                wrIdx     <= {2'b00, reqNk};
                phase     <= '0;
                rcon      <= 8'h01;
                key_valid <= 1'b0;
                err       <= 1'b0;
            end else if (badReq) begin
                err <= 1'b1;
            end
            if (stateQ == EXPAND) begin
                wordBuf[wrIdx] <= newWord;
                wrIdx          <= wrIdx + 6'd1;
                phase          <= (phase == nkQ - 4'd1) ? 4'd0 : phase + 4'd1;
                if (phase == 4'd0) begin
                    rcon <= xtime(rcon);
                end
                if (lastWord) begin
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule
